// File: rtl/ram_port_arbiter_if.sv
// Port bundle for the dpram port A arbiter.
// Carries the CPU, SPI and dpram sides.
interface ram_port_arbiter_if;
  logic        hold_cpu;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait_n;
  logic        spi_req;
  logic        spi_we;
  logic [31:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;
  logic        spi_ack;
  logic        spi_err;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport master (
    output hold_cpu,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_wait_n,
    output spi_req, spi_we, spi_addr, spi_wdata,
    input  spi_rdata, spi_ack, spi_err,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  hold_cpu,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_wait_n,
    input  spi_req, spi_we, spi_addr, spi_wdata,
    output spi_rdata, spi_ack, spi_err,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Request/ack arbiter sharing dpram port A
// between the Z80 CPU and the ESP32 SPI slave.
module ram_port_arbiter #(
  parameter logic [15:0] RAM_BASE     = 16'h4000,
  parameter logic [31:0] SPI_MAX_ADDR = 32'h0000BFFF,
  parameter logic [3:0]  STARVE_LIMIT = 4'd4
) (
  input logic               clk,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    CAP,
    ACK
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_spi;
  logic        in_range;
  logic        acc_we;
  logic [3:0]  starve_cnt;
  logic        cpu_ok;
  logic        grant_cpu;
  logic        grant_spi;
  logic        cpu_in;
  logic        spi_in;
  logic [15:0] cpu_ram_addr;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  cpu_rdata;
  logic [7:0]  spi_rdata;
  logic [7:0]  cap_data;
  logic        cpu_ack;
  logic        spi_ack;
  logic        spi_err;

  assign cpu_ok    = bus.cpu_req & ~bus.hold_cpu;
  assign grant_cpu = (state == IDLE) & cpu_ok &
                     (~bus.spi_req | (starve_cnt < STARVE_LIMIT));
  assign grant_spi = (state == IDLE) & ~grant_cpu & bus.spi_req;

  assign cpu_in       = bus.cpu_addr >= RAM_BASE;
  assign cpu_ram_addr = bus.cpu_addr - RAM_BASE;
  assign spi_in       = bus.spi_addr <= SPI_MAX_ADDR;
  assign cap_data     = in_range ? bus.ram_rdata : 8'hFF;

  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.spi_rdata  = spi_rdata;
  assign bus.cpu_ack    = cpu_ack;
  assign bus.spi_ack    = spi_ack;
  assign bus.spi_err    = spi_err;
  assign bus.cpu_wait_n = reset | ~(bus.cpu_req & ~cpu_ack);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // fixed four-step access sequence
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_cpu | grant_spi) state_nxt = ACC;
      ACC:     state_nxt = CAP;
      CAP:     state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant latch, dpram drive, read capture and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_spi <= 1'b0;
      in_range  <= 1'b0;
      acc_we    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 16'h0000;
      ram_wdata <= 8'h00;
      cpu_rdata <= 8'hFF;
      spi_rdata <= 8'hFF;
      cpu_ack   <= 1'b0;
      spi_ack   <= 1'b0;
      spi_err   <= 1'b0;
    end else begin
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;
      spi_ack <= 1'b0;
      spi_err <= 1'b0;
      if (grant_cpu) begin
        owner_spi <= 1'b0;
        in_range  <= cpu_in;
        acc_we    <= bus.cpu_we;
        ram_addr  <= cpu_ram_addr;
        ram_wdata <= bus.cpu_wdata;
        ram_we    <= bus.cpu_we & cpu_in;
      end else if (grant_spi) begin
        owner_spi <= 1'b1;
        in_range  <= spi_in;
        acc_we    <= bus.spi_we;
        ram_addr  <= bus.spi_addr[15:0];
        ram_wdata <= bus.spi_wdata;
        ram_we    <= bus.spi_we & spi_in;
      end
      if (state == CAP) begin
        if (owner_spi) begin
          spi_ack <= 1'b1;
          spi_err <= ~in_range;
          if (!acc_we) spi_rdata <= cap_data;
        end else begin
          cpu_ack <= 1'b1;
          if (!acc_we) cpu_rdata <= cap_data;
        end
      end
    end
  end

  // consecutive CPU grants while SPI waits
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (grant_spi | ~bus.spi_req)
        starve_cnt <= 4'd0;
      else if (grant_cpu && starve_cnt != 4'd15)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter
// with a behavioural dpram on port A.
module tb_ram_port_arbiter;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   we_cyc = 0;
  logic [15:0] we_addr = '0;
  logic [7:0]  we_data = '0;
  logic        prev_we = 1'b0;
  logic [7:0]  mem [0:65535];
  logic [7:0]  shadow [0:65535];
  logic [7:0]  rd_q = 8'h00;
  exp_t cpu_q[$];
  exp_t spi_q[$];
  logic order_q[$];

  ram_port_arbiter_if bus();

  ram_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // dpram port A: one-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    rd_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = rd_q;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // monitor: scoreboard pops and per-cycle checks
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      if (bus.ram_we) begin
        check("ram_we_pulse", prev_we, 0);
        we_cnt++;
        we_cyc  = cyc;
        we_addr = bus.ram_addr;
        we_data = bus.ram_wdata;
      end
      if (bus.cpu_req)
        check("cpu_wait_n", bus.cpu_wait_n, bus.cpu_ack);
      if (bus.cpu_ack) begin
        check("ack_excl", bus.spi_ack, 0);
        if (order_q.size() > 0)
          check("grant_order", 0, order_q.pop_front());
        if (cpu_q.size() == 0) begin
          check("cpu_extra_ack", bus.cpu_ack, 0);
        end else begin
          e = cpu_q.pop_front();
          if (e.rd) check("cpu_rdata", bus.cpu_rdata, e.data);
        end
      end
      if (bus.spi_ack) begin
        if (order_q.size() > 0)
          check("grant_order", 1, order_q.pop_front());
        if (spi_q.size() == 0) begin
          check("spi_extra_ack", bus.spi_ack, 0);
        end else begin
          e = spi_q.pop_front();
          check("spi_err", bus.spi_err, e.err);
          if (e.rd) check("spi_rdata", bus.spi_rdata, e.data);
        end
      end else begin
        check("spi_err_idle", bus.spi_err, 0);
      end
    end
    prev_we = bus.ram_we;
  end

  task automatic cpu_acc(input logic we,
                         input logic [15:0] a,
                         input logic [7:0] d,
                         output int lat);
    exp_t e;
    logic [15:0] ra;
    ra = a - 16'h4000;
    e.rd = !we;
    e.err = 1'b0;
    e.data = (a >= 16'h4000) ? shadow[ra] : 8'hFF;
    if (we && a >= 16'h4000) shadow[ra] = d;
    cpu_q.push_back(e);
    bus.cpu_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    bus.cpu_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.cpu_ack && lat < 100);
    if (!bus.cpu_ack) check("cpu_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
  endtask

  task automatic spi_acc(input logic we,
                         input logic [31:0] a,
                         input logic [7:0] d,
                         output int lat);
    exp_t e;
    e.rd = !we;
    e.err = a > 32'h0000BFFF;
    e.data = e.err ? 8'hFF : shadow[a[15:0]];
    if (we && !e.err) shadow[a[15:0]] = d;
    spi_q.push_back(e);
    bus.spi_we = we;
    bus.spi_addr = a;
    bus.spi_wdata = d;
    bus.spi_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.spi_ack && lat < 100);
    if (!bus.spi_ack) check("spi_timeout", 0, 1);
    @(posedge clk);
    #1 bus.spi_req = 1'b0;
  endtask

  initial begin
    int lat;
    int l2;
    int c0;
    int w0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    bus.hold_cpu = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.spi_req = 1'b0;
    bus.spi_we = 1'b0;
    bus.spi_addr = '0;
    bus.spi_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_wdata", bus.ram_wdata, 0);
    check("rst_acks", {bus.cpu_ack, bus.spi_ack, bus.spi_err}, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'hFF);
    check("rst_spi_rdata", bus.spi_rdata, 8'hFF);
    check("rst_wait_n", bus.cpu_wait_n, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    c0 = cyc;
    w0 = we_cnt;
    cpu_acc(1, 16'h4000, 8'hA5, lat);
    check("wr_lat", lat, 4);
    check("wr_we_cnt", we_cnt - w0, 1);
    check("wr_we_cyc", we_cyc - c0, 2);
    check("wr_we_addr", we_addr, 16'h0000);
    check("wr_we_data", we_data, 8'hA5);
    cpu_acc(0, 16'h4000, 8'h00, lat);
    check("rd_lat", lat, 4);

    w0 = we_cnt;
    cpu_acc(1, 16'h1234, 8'h55, lat);
    check("rom_wr_lat", lat, 4);
    check("rom_wr_no_we", we_cnt - w0, 0);
    cpu_acc(0, 16'h1234, 8'h00, lat);

    w0 = we_cnt;
    spi_acc(1, 32'h0000C000, 8'h99, lat);
    check("spi_oor_lat", lat, 4);
    check("spi_oor_no_we", we_cnt - w0, 0);
    spi_acc(1, 32'h0000BFFF, 8'h3C, lat);
    check("spi_top_we_cnt", we_cnt - w0, 1);
    check("spi_top_addr", we_addr, 16'hBFFF);
    check("spi_top_data", we_data, 8'h3C);
    cpu_acc(0, 16'hFFFF, 8'h00, lat);
    spi_acc(0, 32'h0000BFFF, 8'h00, lat);
    spi_acc(0, 32'h00010000, 8'h00, lat);

    for (int i = 0; i < 2; i++) begin
      repeat (4) order_q.push_back(1'b0);
      order_q.push_back(1'b1);
    end
    fork
      begin
        repeat (8) cpu_acc(0, 16'h4000, 8'h00, lat);
      end
      begin
        repeat (2) spi_acc(0, 32'h0000BFFF, 8'h00, l2);
      end
    join
    check("order_drained", order_q.size(), 0);

    bus.hold_cpu = 1'b1;
    order_q.push_back(1'b1);
    order_q.push_back(1'b1);
    order_q.push_back(1'b0);
    fork
      cpu_acc(0, 16'h4000, 8'h00, lat);
      begin
        spi_acc(0, 32'h0000BFFF, 8'h00, l2);
        spi_acc(0, 32'h0000BFFF, 8'h00, l2);
        check("hold_wait_n", bus.cpu_wait_n, 0);
        bus.hold_cpu = 1'b0;
        l2 = 0;
        do begin
          @(negedge clk);
          l2++;
        end while (!bus.cpu_ack && l2 < 20);
        check("hold_release_lat", l2, 4);
      end
    join
    check("hold_order_drained", order_q.size(), 0);

    spi_acc(0, 32'h0000BFFF, 8'h00, lat);
    cpu_acc(0, 16'h4000, 8'h00, lat);
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 16'h4010;
    bus.cpu_wdata = 8'h77;
    bus.cpu_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ram_we && lat < 20);
    check("abort_saw_acc", bus.ram_we, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_ram_we", bus.ram_we, 0);
    check("abort_cpu_ack", bus.cpu_ack, 0);
    check("abort_wait_n", bus.cpu_wait_n, 1);
    check("abort_cpu_rdata", bus.cpu_rdata, 8'hFF);
    check("abort_spi_rdata", bus.spi_rdata, 8'hFF);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_ack", bus.cpu_ack, 0);
    @(posedge clk);
    #1;
    cpu_acc(0, 16'h4000, 8'h00, lat);
    check("post_rst_lat", lat, 4);

    repeat (2) @(negedge clk);
    check("cpu_q_empty", cpu_q.size(), 0);
    check("spi_q_empty", spi_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
